// File: rtl/dmem_req_ctrl.sv
// MEM-stage data-memory request controller on an SRAM-like bus: one outstanding access, flush drain.
// Define DMEM_LOAD_EXT_EN to byte/half-select and extend load data here rather than in WB.
module dmem_req_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid_i,
  input  logic        mem_ren_i,
  input  logic        mem_wen_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_lsign_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        stall_i,
  input  logic        refresh_i,
  output logic        stall_req_o,
  output logic [31:0] mem_rdata_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic        discard_q;
  logic        data_req_q;
  logic        data_wr_q;
  logic [1:0]  data_size_q;
  logic [31:0] data_addr_q;
  logic [31:0] data_wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        new_acc;
  logic        finish;

`ifdef DMEM_LOAD_EXT_EN
  logic        lsign_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
`else
  logic        unused_lsign;
  assign unused_lsign = mem_lsign_i;
`endif

  assign new_acc = mem_valid_i & (mem_ren_i | mem_wen_i);
  // Data may come back in the same cycle the address is accepted.
  assign finish  = (((state_q == S_REQ) & data_addr_ok_i) | (state_q == S_WAIT)) & data_data_ok_i;

  always_comb begin
    rdata_d = data_rdata_i;
`ifdef DMEM_LOAD_EXT_EN
    byte_v = data_rdata_i[{data_addr_q[1:0], 3'b000} +: 8];
    half_v = data_rdata_i[{data_addr_q[1], 4'b0000} +: 16];
    case (data_size_q)
      2'd0:    rdata_d = {{24{lsign_q & byte_v[7]}}, byte_v};
      2'd1:    rdata_d = {{16{lsign_q & half_v[15]}}, half_v};
      default: rdata_d = data_rdata_i;
    endcase
`endif
    if (data_wr_q) rdata_d = '0;
  end

  // A flushed slot never stalls; during a drain only a fresh access has to wait.
  always_comb begin
    stall_req_o = 1'b0;
    case (state_q)
      S_IDLE:        stall_req_o = new_acc & ~refresh_i;
      S_REQ, S_WAIT: stall_req_o = ~refresh_i & (~discard_q | new_acc);
      default:       stall_req_o = 1'b0;
    endcase
    if (!resetn) stall_req_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      discard_q    <= 1'b0;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      rdata_q      <= '0;
`ifdef DMEM_LOAD_EXT_EN
      lsign_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (refresh_i) begin
            rdata_q <= '0;
          end else if (new_acc) begin
            state_q      <= S_REQ;
            data_req_q   <= 1'b1;
            data_wr_q    <= mem_wen_i;
            data_size_q  <= mem_size_i;
            data_addr_q  <= mem_addr_i;
            data_wdata_q <= mem_wdata_i;
`ifdef DMEM_LOAD_EXT_EN
            lsign_q      <= mem_lsign_i;
`endif
          end
        end
        S_REQ, S_WAIT: begin
          if (refresh_i) discard_q <= 1'b1;
          if (data_addr_ok_i) data_req_q <= 1'b0;
          if (finish) begin
            if (discard_q | refresh_i) begin
              state_q   <= S_IDLE;
              discard_q <= 1'b0;
            end else begin
              state_q <= S_DONE;
              rdata_q <= rdata_d;
            end
          end else if ((state_q == S_REQ) && data_addr_ok_i) begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          if (refresh_i) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
          end else if (!stall_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rdata_o  = rdata_q;
  assign data_req_o   = data_req_q;
  assign data_wr_o    = data_wr_q;
  assign data_size_o  = data_size_q;
  assign data_addr_o  = data_addr_q;
  assign data_wdata_o = data_wdata_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: directed corner cases then randomized accesses against a transaction model.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_ren, mem_wen, mem_lsign, stall, refresh;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall_req, data_req, data_wr, data_addr_ok, data_data_ok;
  logic [31:0] mem_rdata, data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_buf = '0;

  always #5 clk = ~clk;

  dmem_req_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_valid_i    (mem_valid),
    .mem_ren_i      (mem_ren),
    .mem_wen_i      (mem_wen),
    .mem_size_i     (mem_size),
    .mem_lsign_i    (mem_lsign),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .stall_i        (stall),
    .refresh_i      (refresh),
    .stall_req_o    (stall_req),
    .mem_rdata_o    (mem_rdata),
    .data_req_o     (data_req),
    .data_wr_o      (data_wr),
    .data_size_o    (data_size),
    .data_addr_o    (data_addr),
    .data_wdata_o   (data_wdata),
    .data_addr_ok_i (data_addr_ok),
    .data_data_ok_i (data_data_ok),
    .data_rdata_i   (data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value the pipeline should see for a completed access.
  function automatic logic [31:0] fmt(input bit wr, input logic [1:0] sz, input bit ls,
                                      input logic [31:0] addr, input logic [31:0] rd);
    longint v;
    longint span;
    int     off;
    off  = int'(addr % 32'd4);
    span = (sz == 2'd0) ? 256 : 65536;
    v    = ({32'd0, rd} >> (8 * off)) % span;
    if (ls && v >= span / 2) v = v - span;
    if (sz == 2'd2) v = {32'd0, rd};
    if (wr) return 32'd0;
`ifdef DMEM_LOAD_EXT_EN
    return v[31:0];
`else
    return rd;
`endif
  endfunction

  task automatic do_access(input bit wr, input logic [1:0] sz, input bit ls, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int a_dly,
                           input int d_dly, input int hold, input bit fl_done);
    logic [31:0] exp;
    exp = fmt(wr, sz, ls, addr, rd);
    @(negedge clk);
    mem_valid = 1'b1; mem_ren = !wr; mem_wen = wr; mem_size = sz;
    mem_lsign = ls; mem_addr = addr; mem_wdata = wd;
    #1;
    chk("idle_stall", 32'(stall_req), 1);
    chk("idle_rdata", mem_rdata, model_buf);
    chk("idle_noreq", 32'(data_req), 0);
    for (int k = 0; k <= a_dly; k++) begin
      @(negedge clk);
      mem_addr = $urandom; mem_wdata = $urandom;
      data_addr_ok = (k == a_dly);
      data_data_ok = (k == a_dly) && (d_dly == 0);
      data_rdata   = data_data_ok ? rd : $urandom;
      #1;
      chk("req_vld", 32'(data_req), 1);
      chk("req_addr", data_addr, addr);
      chk("req_wr", 32'(data_wr), 32'(wr));
      chk("req_size", 32'(data_size), 32'(sz));
      if (wr) chk("req_wdata", data_wdata, wd);
      chk("req_stall", 32'(stall_req), 1);
    end
    for (int j = 1; j <= d_dly; j++) begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = (j == d_dly);
      data_rdata   = data_data_ok ? rd : $urandom;
      #1;
      chk("wait_noreq", 32'(data_req), 0);
      chk("wait_stall", 32'(stall_req), 1);
    end
    model_buf = exp;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      stall   = (h < hold);
      refresh = fl_done && (h == hold);
      #1;
      chk("done_stall", 32'(stall_req), 0);
      chk("done_rdata", mem_rdata, exp);
      chk("done_noreq", 32'(data_req), 0);
    end
    if (fl_done) model_buf = '0;
    @(negedge clk);
    stall = 1'b0; refresh = 1'b0; mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
  endtask

  // Load flushed in REQ (in_req=1) or WAIT; nxt models a younger access arriving during the drain.
  task automatic do_flushed(input bit in_req, input int a_dly, input int d_dly, input bit nxt);
    bit   fl;
    logic e;
    @(negedge clk);
    mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_size = 2'd2;
    mem_addr = $urandom & 32'hFFFF_FFFC;
    #1;
    chk("fidle_stall", 32'(stall_req), 1);
    fl = 1'b0;
    for (int k = 0; k <= a_dly; k++) begin
      @(negedge clk);
      refresh = in_req && (k == 0);
      if (refresh) mem_valid = 1'b0; else if (fl) mem_valid = nxt;
      data_addr_ok = (k == a_dly); data_data_ok = 1'b0;
      #1;
      e = refresh ? 1'b0 : (fl ? nxt : 1'b1);
      chk("freq_vld", 32'(data_req), 1);
      chk("freq_stall", 32'(stall_req), 32'(e));
      if (refresh) fl = 1'b1;
    end
    for (int j = 1; j <= d_dly; j++) begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      refresh = !in_req && (j == 1);
      if (refresh) mem_valid = 1'b0; else if (fl) mem_valid = nxt;
      data_data_ok = (j == d_dly);
      data_rdata   = 32'hAAAA5555;
      #1;
      e = refresh ? 1'b0 : (fl ? nxt : 1'b1);
      chk("fwait_noreq", 32'(data_req), 0);
      chk("fwait_stall", 32'(stall_req), 32'(e));
      chk("fwait_rdata", mem_rdata, model_buf);
      if (refresh) fl = 1'b1;
    end
    @(negedge clk);
    refresh = 1'b0; data_data_ok = 1'b0; mem_valid = 1'b0;
    #1;
    chk("fdrain_stall", 32'(stall_req), 0);
    chk("fdrain_rdata", mem_rdata, model_buf);
    chk("fdrain_noreq", 32'(data_req), 0);
  endtask

  task automatic idle_flush();
    @(negedge clk);
    mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; refresh = 1'b1;
    #1;
    chk("iflush_stall", 32'(stall_req), 0);
    @(negedge clk);
    mem_valid = 1'b0; refresh = 1'b0;
    model_buf = '0;
    #1;
    chk("iflush_noreq", 32'(data_req), 0);
    chk("iflush_rdata", mem_rdata, model_buf);
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_size = 2'd2;
    mem_addr = 32'h3000; mem_wdata = 32'h5A5A5A5A;
    #1;
    chk("rst_idle_stall", 32'(stall_req), 1);
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    chk("rst_req_vld", 32'(data_req), 1);
    @(negedge clk);
    data_addr_ok = 1'b0; resetn = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_buf = '0;
    #1;
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_req", 32'(data_req), 0);
    chk("rst_wr", 32'(data_wr), 0);
    chk("rst_size", 32'(data_size), 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_rdata", mem_rdata, model_buf);
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  sz;
    bit          wr, ir;
    int          kind;

    resetn = 1'b0; mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_size = '0;
    mem_lsign = 1'b0; mem_addr = '0; mem_wdata = '0; stall = 1'b0; refresh = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("por_stall", 32'(stall_req), 0);
    chk("por_req", 32'(data_req), 0);
    chk("por_rdata", mem_rdata, 0);
    chk("por_addr", data_addr, 0);
    chk("por_wdata", data_wdata, 0);
    chk("por_wr", 32'(data_wr), 0);
    @(negedge clk);
    resetn = 1'b1;

    do_access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 2, 0, 1'b0);
    do_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80112233, 0, 1, 0, 1'b0);
    do_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80112233, 1, 0, 0, 1'b0);
    do_access(1'b1, 2'd2, 1'b0, 32'h2000, 32'h12345678, 32'hCAFEF00D, 3, 1, 0, 1'b0);
    do_access(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h9ABC1234, 0, 0, 3, 1'b0);
    do_flushed(1'b0, 0, 3, 1'b1);
    do_access(1'b0, 2'd1, 1'b0, 32'h4000, 32'h0, 32'h0000F00F, 0, 1, 0, 1'b0);
    do_flushed(1'b1, 2, 2, 1'b0);
    do_access(1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 32'h13579BDF, 0, 1, 1, 1'b1);
    do_access(1'b0, 2'd2, 1'b0, 32'h4008, 32'h0, 32'h2468ACE0, 0, 1, 0, 1'b0);
    idle_flush();
    reset_in_wait();

    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        wr   = 1'($urandom_range(0, 1));
        sz   = 2'($urandom_range(0, 2));
        addr = $urandom;
        if (sz == 2'd1) addr[0] = 1'b0;
        else if (sz == 2'd2) addr[1:0] = 2'b00;
        do_access(wr, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  $urandom_range(0, 7) == 0);
      end else if (kind <= 8) begin
        ir = 1'($urandom_range(0, 1));
        do_flushed(ir, $urandom_range(0, 2),
                   ir ? $urandom_range(1, 3) : $urandom_range(2, 4), 1'($urandom_range(0, 1)));
      end else begin
        idle_flush();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
